// File: rtl/bp_me_pkg.sv
// rtl/bp_me_pkg.sv - BedRock memory-interface checker types and helpers
//
// Purpose: shared types for bp_me_mem_resp_checker.
//   bp_me_resp_check_err_e              : checker error codes (0 = none)
//   DECLARE_BP_ME_RESP_CHECK_ENTRY_S    : scoreboard entry {msg_type, addr, size}
//   BP_ME_RESP_CHECK_ENTRY_WIDTH        : packed width of that entry
//   bp_me_resp_check_prio               : picks the reported code among new errors

`ifndef BP_ME_PKG_SV
`define BP_ME_PKG_SV

`define DECLARE_BP_ME_RESP_CHECK_ENTRY_S(paddr_width_mp) \
    typedef struct packed {                               \
        logic [3:0]                msg_type;              \
        logic [paddr_width_mp-1:0] addr;                  \
        logic [2:0]                size;                  \
    } bp_me_resp_check_entry_s

`define BP_ME_RESP_CHECK_ENTRY_WIDTH(paddr_width_mp) (4 + (paddr_width_mp) + 3)

package bp_me_pkg;

    typedef enum logic [2:0] {
        e_chk_none       = 3'd0,
        e_chk_overflow   = 3'd1,
        e_chk_unexpected = 3'd2,
        e_chk_mismatch   = 3'd3,
        e_chk_timeout    = 3'd4
    } bp_me_resp_check_err_e;

    // new_flags = {overflow, unexpected, mismatch, timeout}
    function automatic bp_me_resp_check_err_e bp_me_resp_check_prio(input logic [3:0] new_flags);
        if (new_flags[3])      return e_chk_overflow;
        else if (new_flags[2]) return e_chk_unexpected;
        else if (new_flags[1]) return e_chk_mismatch;
        else if (new_flags[0]) return e_chk_timeout;
        else                   return e_chk_none;
    endfunction

endpackage

`endif

// File: rtl/bsg_mem_1r1w.sv
// rtl/bsg_mem_1r1w.sv - one-write one-async-read register-file storage
//
// Purpose: els_p x width_p storage, synchronous write, combinational read.
// Ports:
//   w_clk_i   write clock
//   w_v_i     write enable
//   w_addr_i  write index
//   w_data_i  write data
//   r_addr_i  read index
//   r_data_o  read data (async)

module bsg_mem_1r1w #(
    parameter int width_p = 8,
    parameter int els_p   = 8,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                     w_clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    // Storage is not reset: entries are only read once the pointers say they were written.
    always_ff @(posedge w_clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_me_mem_resp_checker.sv
// rtl/bp_me_mem_resp_checker.sv - in-order command/response protocol checker
//
// Purpose: passive checker at the memory responder end. Accepted commands are
// queued in an in-order scoreboard; each accepted response must match the head.
// Ports:
//   clk_i, reset_n_i                 clock, async active-low reset
//   cmd_*_i                          observed command channel (valid, ready, header)
//   resp_*_i                         observed response channel (valid, ready, header)
//   outstanding_o                    registered scoreboard occupancy
//   err_v_o                          one-cycle pulse on any newly set flag
//   err_code_o                       sticky code of the first error
//   overflow_o/unexpected_o/
//   mismatch_o/timeout_o             sticky error flags

module bp_me_mem_resp_checker
    import bp_me_pkg::*;
#(
    parameter int paddr_width_p = 40,
    parameter int els_p         = 8,
    parameter int timeout_p     = 1024,
    localparam int ptr_width_lp = $clog2(els_p),
    localparam int cnt_width_lp = $clog2(els_p+1)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic                     cmd_v_i,
    input  logic                     cmd_ready_and_i,
    input  logic [3:0]               cmd_msg_type_i,
    input  logic [paddr_width_p-1:0] cmd_addr_i,
    input  logic [2:0]               cmd_size_i,

    input  logic                     resp_v_i,
    input  logic                     resp_ready_and_i,
    input  logic [3:0]               resp_msg_type_i,
    input  logic [paddr_width_p-1:0] resp_addr_i,
    input  logic [2:0]               resp_size_i,

    output logic [cnt_width_lp-1:0]  outstanding_o,
    output logic                     err_v_o,
    output logic [2:0]               err_code_o,
    output logic                     overflow_o,
    output logic                     unexpected_o,
    output logic                     mismatch_o,
    output logic                     timeout_o
);

    `DECLARE_BP_ME_RESP_CHECK_ENTRY_S(paddr_width_p);
    localparam int entry_width_lp = `BP_ME_RESP_CHECK_ENTRY_WIDTH(paddr_width_p);
    localparam int tmr_width_lp   = $clog2(timeout_p+1);

    localparam logic [cnt_width_lp-1:0] els_lp     = cnt_width_lp'(els_p);
    localparam logic [tmr_width_lp-1:0] tmr_max_lp = tmr_width_lp'(timeout_p);
    localparam logic [tmr_width_lp-1:0] tmr_pre_lp = tmr_width_lp'(timeout_p - 1);

    logic [ptr_width_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_width_lp-1:0] count_q, count_d;
    logic [tmr_width_lp-1:0] timer_q, timer_d;
    logic                    overflow_q, unexpected_q, mismatch_q, timeout_q;
    logic                    err_v_q, err_v_d;
    bp_me_resp_check_err_e   err_code_q, err_code_d;

    bp_me_resp_check_entry_s cmd_entry, resp_entry, head_entry;
    logic [entry_width_lp-1:0] head_raw;

    logic cmd_hs, resp_hs, empty, full;
    logic pop_legal, push_accepted, tmr_clear;
    logic overflow_det, unexpected_det, mismatch_det, timeout_det;
    logic [3:0] new_flags;

    assign cmd_entry  = '{msg_type: cmd_msg_type_i,  addr: cmd_addr_i,  size: cmd_size_i};
    assign resp_entry = '{msg_type: resp_msg_type_i, addr: resp_addr_i, size: resp_size_i};
    assign head_entry = bp_me_resp_check_entry_s'(head_raw);

    assign cmd_hs  = cmd_v_i  & cmd_ready_and_i;
    assign resp_hs = resp_v_i & resp_ready_and_i;
    assign empty   = (count_q == '0);
    assign full    = (count_q == els_lp);

    // Occupancy is judged at cycle start, so a same-cycle push never feeds a pop.
    assign pop_legal      = resp_hs & ~empty;
    assign unexpected_det = resp_hs & empty;
    // A pop frees a slot in the same cycle, so push-while-full is legal with a pop.
    assign push_accepted  = cmd_hs & (~full | pop_legal);
    assign overflow_det   = cmd_hs & full & ~pop_legal;
    assign mismatch_det   = pop_legal & (resp_entry != head_entry);

    assign tmr_clear   = pop_legal | empty;
    assign timeout_det = ~tmr_clear & (timer_q == tmr_pre_lp);

    assign new_flags = {overflow_det   & ~overflow_q,
                        unexpected_det & ~unexpected_q,
                        mismatch_det   & ~mismatch_q,
                        timeout_det    & ~timeout_q};

    bsg_mem_1r1w #(
        .width_p (entry_width_lp),
        .els_p   (els_p)
    ) sb_mem (
        .w_clk_i  (clk_i),
        .w_v_i    (push_accepted),
        .w_addr_i (wptr_q),
        .w_data_i (cmd_entry),
        .r_addr_i (rptr_q),
        .r_data_o (head_raw)
    );

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        timer_d    = timer_q;
        err_code_d = err_code_q;

        if (push_accepted) wptr_d = wptr_q + ptr_width_lp'(1);
        if (pop_legal)     rptr_d = rptr_q + ptr_width_lp'(1);

        count_d = count_q + cnt_width_lp'(push_accepted) - cnt_width_lp'(pop_legal);

        if (tmr_clear)               timer_d = '0;
        else if (timer_q != tmr_max_lp) timer_d = timer_q + tmr_width_lp'(1);

        err_v_d = |new_flags;
        if (err_code_q == e_chk_none && err_v_d) begin
            err_code_d = bp_me_resp_check_prio(new_flags);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            timer_q      <= '0;
            overflow_q   <= 1'b0;
            unexpected_q <= 1'b0;
            mismatch_q   <= 1'b0;
            timeout_q    <= 1'b0;
            err_v_q      <= 1'b0;
            err_code_q   <= e_chk_none;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            timer_q      <= timer_d;
            overflow_q   <= overflow_q   | overflow_det;
            unexpected_q <= unexpected_q | unexpected_det;
            mismatch_q   <= mismatch_q   | mismatch_det;
            timeout_q    <= timeout_q    | timeout_det;
            err_v_q      <= err_v_d;
            err_code_q   <= err_code_d;
        end
    end

    assign outstanding_o = count_q;
    assign err_v_o       = err_v_q;
    assign err_code_o    = err_code_q;
    assign overflow_o    = overflow_q;
    assign unexpected_o  = unexpected_q;
    assign mismatch_o    = mismatch_q;
    assign timeout_o     = timeout_q;

endmodule

// File: doc/bp_me_mem_resp_checker.md
Name: bp_me_mem_resp_checker

Overview:
- Runtime protocol checker for the BedRock CCE-to-memory interface, placed at the responder end. It watches the memory command and response channels.
- Commands are pushed into an in-order scoreboard as they are accepted. Each response must match the scoreboard head on msg_type, addr and size.
- Sticky error flags, an outstanding-request count and a timeout detector are exported for testbench monitors and debug CSRs.
- Passive: it never drives handshake signals.

Parameters:
- paddr_width_p, 40, physical address width of the header addr field
- els_p, 8, scoreboard depth (max outstanding commands); power of two, >= 2
- timeout_p, 1024, cycles a non-empty scoreboard may go without a response before timeout is flagged
- ptr_width_lp, $clog2(els_p), derived scoreboard pointer width
- cnt_width_lp, $clog2(els_p+1), derived outstanding-count width

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- cmd_v_i  in  1  memory command valid
- cmd_ready_and_i  in  1  memory command ready; handshake = cmd_v_i & cmd_ready_and_i
- cmd_msg_type_i  in  4  command bp_bedrock_mem_type_e
- cmd_addr_i  in  paddr_width_p  command address
- cmd_size_i  in  3  command bp_bedrock_msg_size_e
- resp_v_i  in  1  memory response valid
- resp_ready_and_i  in  1  memory response ready; handshake = resp_v_i & resp_ready_and_i
- resp_msg_type_i  in  4  response msg type
- resp_addr_i  in  paddr_width_p  response address
- resp_size_i  in  3  response size
- outstanding_o  out  cnt_width_lp  current scoreboard occupancy
- err_v_o  out  1  one-cycle pulse on any newly detected error
- err_code_o  out  3  sticky code of the first error (0 = none)
- overflow_o  out  1  sticky: command accepted while full with no pop
- unexpected_o  out  1  sticky: response while empty
- mismatch_o  out  1  sticky: response fields differ from head
- timeout_o  out  1  sticky: timeout counter expired

Behaviour:
- Reset
  - Async assert on reset_n_i low; all state clears immediately: outputs 0, pointers 0, count 0, timer 0.
  - Deassert is synchronous to clk_i. The first handshake is observed on the first rising edge with reset_n_i high.
- Push
  - On cmd handshake, write {msg_type, addr, size} at the write pointer, then increment it (wraps mod els_p).
- Pop
  - On resp handshake with count != 0 (count as of cycle start), compare the response fields to the head entry, then increment the read pointer.
  - Any field difference sets mismatch_o (code 3). The entry is popped regardless.
- Empty response
  - Response handshake with count == 0 at cycle start sets unexpected_o (code 2). No pop.
  - A same-cycle push does not satisfy it: a response may never share a cycle with its own command.
- Full push
  - Push with count == els_p and no legal pop in the same cycle sets overflow_o (code 1). The entry is dropped; pointers and count are unchanged.
  - Push and pop together when full is legal: count stays els_p, both pointers advance.
- Count update
  - count_next = count + push_accepted - pop_legal.
  - outstanding_o is registered; it reflects handshakes one cycle later.
- Timer (width $clog2(timeout_p+1))
  - Clears on legal pop or when count == 0; otherwise increments, saturating at timeout_p.
  - When the timer equals timeout_p - 1 and increments, timeout_o sets (code 4). Timer stays saturated; no repeated pulse.
- Error reporting
  - err_v_o pulses for one cycle (registered, one cycle after the offending handshake) whenever any sticky flag transitions 0 to 1.
  - err_code_o latches only if it is currently 0. If several errors are new in one cycle, priority is overflow > unexpected > mismatch > timeout.
  - Flags never clear except by reset.
- Checking continues after an error.
- No combinational path from inputs to outputs.

Decomposition:
- bp_me_pkg additions:
  - typedef bp_me_resp_check_err_e: e_chk_none=0, e_chk_overflow=1, e_chk_unexpected=2, e_chk_mismatch=3, e_chk_timeout=4.
  - Scoreboard entry struct {msg_type, addr, size}, parameterized via a declare macro on paddr_width_p.
- Sub-module: scoreboard storage as bsg_mem_1r1w (els_p x entry width, async read).
- Pointers, count, timer and error logic live in the top module.

Test Plan:
- Basic in order: push rd addr 0x8000_0040 size 64B; 3 cycles later response with same fields -> outstanding_o 0 to 1 to 0, all flags 0, err_v_o never high.
- Fill: push 8 commands (addr 0x0, 0x40 ... 0x1C0) -> outstanding_o = 8.
  - 9th push alone -> overflow_o = 1, err_code_o = 1, err_v_o high exactly 1 cycle, outstanding_o stays 8.
  - 8 matching responses then drain cleanly.
- Full with simultaneous push and pop: at count 8, push 0x200 and pop 0x0 in the same cycle -> no overflow, count stays 8; the last popped entry is 0x200.
- Unexpected: response with count 0 and a push in the same cycle -> unexpected_o = 1, err_code_o = 2; count becomes 1.
- Mismatch then later error: push wr addr 0x100, response addr 0x140 -> mismatch_o = 1, err_code_o = 3, count 0.
  - A later timeout sets timeout_o, but err_code_o stays 3.
- Timeout and reset: timeout_p = 16, one push, no response -> timeout_o rises when the 16th cycle of waiting completes, one err_v_o pulse.
  - Pull reset_n_i low mid-cycle -> all outputs 0 before the next clock edge.
